alu_decode_stage: RTL and testbench

ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

---
 rtl/alu_decode_stage.sv | 177 +++++++++++++++++
 tb/tb_alu_decode_stage.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_decode_stage.sv
// Single registered decode stage: RV32 integer subset to ALU control, register indices and immediate.
// Valid/ready on both sides, flush, and a saturating count of accepted illegal instructions.
module alu_decode_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [31:0]           in_instr,
    output logic                  in_ready,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0]            alu_control,
    output logic [4:0]            rs1_idx,
    output logic [4:0]            rs2_idx,
    output logic [4:0]            rd_idx,
    output logic [DATA_WIDTH-1:0] imm,
    output logic                  use_imm,
    output logic                  is_branch,
    output logic                  illegal,
    output logic [CNT_WIDTH-1:0]  illegal_count
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    localparam logic [3:0] ALU_ADD   = 4'h0;
    localparam logic [3:0] ALU_SUB   = 4'h1;
    localparam logic [3:0] ALU_SLL   = 4'h2;
    localparam logic [3:0] ALU_SLT   = 4'h3;
    localparam logic [3:0] ALU_SLTU  = 4'h4;
    localparam logic [3:0] ALU_XOR   = 4'h5;
    localparam logic [3:0] ALU_SRL   = 4'h6;
    localparam logic [3:0] ALU_SRA   = 4'h7;
    localparam logic [3:0] ALU_OR    = 4'h8;
    localparam logic [3:0] ALU_AND   = 4'h9;
    localparam logic [3:0] ALU_ZERO  = 4'hA;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    logic                  d_legal;
    logic [3:0]            d_alu;
    logic [4:0]            d_rs1;
    logic [DATA_WIDTH-1:0] d_imm;
    logic                  d_use_imm;
    logic                  d_branch;
    logic                  accept;
    logic                  is_shift;

    assign opcode   = in_instr[6:0];
    assign funct3   = in_instr[14:12];
    assign funct7   = in_instr[31:25];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    // funct3 to ALU code; alt selects SUB/SRA on the two funct3 values that have one
    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
        logic [3:0] code;
        case (f3)
            3'b000:  code = alt ? ALU_SUB : ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = alt ? ALU_SRA : ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

    // Combinational decode of the incoming instruction
    always_comb begin
        d_legal   = 1'b0;
        d_alu     = ALU_ZERO;
        d_rs1     = in_instr[19:15];
        d_imm     = '0;
        d_use_imm = 1'b0;
        d_branch  = 1'b0;
        case (opcode)
            OP_R: begin
                d_legal = (funct7 == F7_BASE) ||
                          ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
                d_alu   = alu_of(funct3, funct7[5]);
            end
            OP_I: begin
                d_legal   = !is_shift || (funct7 == F7_BASE) ||
                            ((funct7 == F7_ALT) && (funct3 == 3'b101));
                d_alu     = alu_of(funct3, is_shift && funct7[5]);
                d_use_imm = 1'b1;
                d_imm     = is_shift ? DATA_WIDTH'(in_instr[24:20])
                                     : DATA_WIDTH'($signed(in_instr[31:20]));
            end
            OP_BRANCH: begin
                d_legal  = (funct3 == 3'b000) || (funct3 == 3'b001);
                d_alu    = ALU_SUB;
                d_branch = 1'b1;
                d_imm    = DATA_WIDTH'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                                in_instr[11:8], 1'b0}));
            end
            OP_LOAD: begin
                d_legal   = 1'b1;
                d_alu     = ALU_ADD;
                d_use_imm = 1'b1;
                d_imm     = DATA_WIDTH'($signed(in_instr[31:20]));
            end
            OP_STORE: begin
                d_legal   = 1'b1;
                d_alu     = ALU_ADD;
                d_use_imm = 1'b1;
                d_imm     = DATA_WIDTH'($signed({in_instr[31:25], in_instr[11:7]}));
            end
            OP_LUI: begin
                d_legal   = 1'b1;
                d_alu     = ALU_ADD;
                d_rs1     = 5'd0;
                d_use_imm = 1'b1;
                d_imm     = DATA_WIDTH'($signed({in_instr[31:12], 12'b0}));
            end
            default: d_legal = 1'b0;
        endcase
        // Illegal encodings present a neutral zero-result op with raw indices
        if (!d_legal) begin
            d_alu     = ALU_ZERO;
            d_imm     = '0;
            d_use_imm = 1'b0;
            d_branch  = 1'b0;
        end
    end

    // Output register; flush wins, then acceptance, then drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid     <= 1'b0;
            alu_control   <= ALU_ZERO;
            rs1_idx       <= 5'd0;
            rs2_idx       <= 5'd0;
            rd_idx        <= 5'd0;
            imm           <= '0;
            use_imm       <= 1'b0;
            is_branch     <= 1'b0;
            illegal       <= 1'b0;
            illegal_count <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            alu_control <= d_alu;
            rs1_idx     <= d_rs1;
            rs2_idx     <= in_instr[24:20];
            rd_idx      <= in_instr[11:7];
            imm         <= d_imm;
            use_imm     <= d_use_imm;
            is_branch   <= d_branch;
            illegal     <= !d_legal;
            if (!d_legal && (illegal_count != {CNT_WIDTH{1'b1}})) begin
                illegal_count <= illegal_count + CNT_WIDTH'(1);
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed bench for alu_decode_stage: reference decoder and stage model checked every cycle,
// plus hand-computed literal expectations at key points.
module tb_alu_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = 32'h0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, use_imm, is_branch, illegal;
    logic [3:0]  alu_control;
    logic [4:0]  rs1_idx, rs2_idx, rd_idx;
    logic [31:0] imm;
    logic [15:0] illegal_count;

    logic        s_in_ready, s_out_valid, s_use_imm, s_is_branch, s_illegal;
    logic [3:0]  s_alu_control;
    logic [4:0]  s_rs1_idx, s_rs2_idx, s_rd_idx;
    logic [31:0] s_imm;
    logic [1:0]  s_illegal_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_decode_stage #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .alu_control(alu_control),
        .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rd_idx(rd_idx), .imm(imm), .use_imm(use_imm),
        .is_branch(is_branch), .illegal(illegal), .illegal_count(illegal_count)
    );

    // Narrow counter copy shares all inputs to exercise saturation quickly
    alu_decode_stage #(.DATA_WIDTH(32), .CNT_WIDTH(2)) dut_small (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(s_in_ready),
        .flush(flush), .out_valid(s_out_valid), .out_ready(out_ready), .alu_control(s_alu_control),
        .rs1_idx(s_rs1_idx), .rs2_idx(s_rs2_idx), .rd_idx(s_rd_idx), .imm(s_imm), .use_imm(s_use_imm),
        .is_branch(s_is_branch), .illegal(s_illegal), .illegal_count(s_illegal_count)
    );

    typedef struct packed {
        logic [3:0]  alu;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        ui;
        logic        br;
        logic        il;
    } dec_t;

    localparam dec_t RESET_DEC = '{alu: 4'hA, rs1: 5'd0, rs2: 5'd0, rd: 5'd0, imm: 32'h0,
                                   ui: 1'b0, br: 1'b0, il: 1'b0};

    // Reference decoder: base code per funct3, +1 for the alternate (SUB/SRA) form
    function automatic dec_t ref_decode(input logic [31:0] i);
        int    base [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        int    op = int'(i[6:0]);
        int    f3 = int'(i[14:12]);
        int    f7 = int'(i[31:25]);
        bit    ok = 1'b0;
        bit    shift = (f3 == 1) || (f3 == 5);
        dec_t  d;
        d = '{alu: 4'hA, rs1: i[19:15], rs2: i[24:20], rd: i[11:7], imm: 32'h0,
              ui: 1'b0, br: 1'b0, il: 1'b0};
        case (op)
            51: begin
                ok    = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
                d.alu = 4'(base[f3] + ((f7 == 32) ? 1 : 0));
            end
            19: begin
                ok    = !shift || (f7 == 0) || (f7 == 32 && f3 == 5);
                d.alu = 4'(base[f3] + ((shift && f7 == 32) ? 1 : 0));
                d.ui  = 1'b1;
                d.imm = shift ? {27'h0, i[24:20]} : {{20{i[31]}}, i[31:20]};
            end
            99: begin
                ok    = (f3 < 2);
                d.alu = 4'd1;
                d.br  = 1'b1;
                d.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            end
            3: begin
                ok = 1'b1; d.alu = 4'd0; d.ui = 1'b1;
                d.imm = {{20{i[31]}}, i[31:20]};
            end
            35: begin
                ok = 1'b1; d.alu = 4'd0; d.ui = 1'b1;
                d.imm = {{20{i[31]}}, i[31:25], i[11:7]};
            end
            55: begin
                ok = 1'b1; d.alu = 4'd0; d.ui = 1'b1; d.rs1 = 5'd0;
                d.imm = {i[31:12], 12'h000};
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            d.alu = 4'hA; d.ui = 1'b0; d.br = 1'b0; d.imm = 32'h0; d.il = 1'b1;
        end
        return d;
    endfunction

    // Stage model: held decode, valid flag and an unbounded illegal tally
    logic m_valid = 1'b0;
    dec_t m_dec   = RESET_DEC;
    int   m_ill   = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_dec   <= RESET_DEC;
            m_ill   <= 0;
        end else if (flush) begin
            m_valid <= 1'b0;
        end else if (in_valid && (!m_valid || out_ready)) begin
            m_valid <= 1'b1;
            m_dec   <= ref_decode(in_instr);
            if (ref_decode(in_instr).il) m_ill <= m_ill + 1;
        end else if (out_ready) begin
            m_valid <= 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("m_in_ready",  32'(in_ready),      32'(!m_valid || out_ready));
        chk("m_out_valid", 32'(out_valid),     32'(m_valid));
        chk("m_alu",       32'(alu_control),   32'(m_dec.alu));
        chk("m_rs1",       32'(rs1_idx),       32'(m_dec.rs1));
        chk("m_rs2",       32'(rs2_idx),       32'(m_dec.rs2));
        chk("m_rd",        32'(rd_idx),        32'(m_dec.rd));
        chk("m_imm",       imm,                m_dec.imm);
        chk("m_flags",     {29'h0, use_imm, is_branch, illegal}, {29'h0, m_dec.ui, m_dec.br, m_dec.il});
        chk("m_count",     32'(illegal_count), 32'((m_ill > 65535) ? 65535 : m_ill));
        chk("m_count_sat", 32'(s_illegal_count), 32'((m_ill > 3) ? 3 : m_ill));
    end

    // Drive one cycle of inputs just after a rising edge, then land just after the next one
    task automatic cyc(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
        in_valid  = v;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_alu",   32'(alu_control), 32'hA);
        chk("rst_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        cyc(1'b0, 32'h0, 1'b1, 1'b0);

        cyc(1'b1, 32'h002081B3, 1'b1, 1'b0);
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_alu",   32'(alu_control), 32'd0);
        chk("add_idx",   {17'h0, rs1_idx, rs2_idx, rd_idx}, {17'h0, 5'd1, 5'd2, 5'd3});
        chk("add_flags", {30'h0, use_imm, illegal}, 32'd0);

        cyc(1'b1, 32'h40335293, 1'b1, 1'b0);
        chk("srai_alu", 32'(alu_control), 32'd7);
        chk("srai_imm", imm, 32'h00000003);
        chk("srai_ui",  32'(use_imm), 32'd1);

        cyc(1'b1, 32'hFFF00093, 1'b1, 1'b0);
        chk("addi_alu", 32'(alu_control), 32'd0);
        chk("addi_imm", imm, 32'hFFFFFFFF);

        cyc(1'b1, 32'h00208463, 1'b1, 1'b0);
        chk("beq_alu", 32'(alu_control), 32'd1);
        chk("beq_br",  32'(is_branch), 32'd1);
        chk("beq_imm", imm, 32'h00000008);

        cyc(1'b1, 32'h123450B7, 1'b1, 1'b0);
        chk("lui_rs1", 32'(rs1_idx), 32'd0);
        chk("lui_imm", imm, 32'h12345000);

        cyc(1'b1, 32'hFFC0A103, 1'b1, 1'b0);
        cyc(1'b1, 32'hFE20AE23, 1'b1, 1'b0);
        cyc(1'b1, 32'h0020F1B3, 1'b1, 1'b0);
        cyc(1'b1, 32'h00309093, 1'b1, 1'b0);

        // Backpressure: held output and blocked input, then back-to-back drain
        cyc(1'b1, 32'h402081B3, 1'b1, 1'b0);
        chk("sub_alu", 32'(alu_control), 32'd1);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 32'h002081B3, 1'b0, 1'b0);
            chk("hold_ready", 32'(in_ready), 32'd0);
            chk("hold_alu",   32'(alu_control), 32'd1);
            chk("hold_valid", 32'(out_valid), 32'd1);
        end
        cyc(1'b1, 32'h002081B3, 1'b1, 1'b0);
        chk("b2b_valid0", 32'(out_valid), 32'd1);
        chk("b2b_alu0",   32'(alu_control), 32'd0);
        cyc(1'b1, 32'hFFF00093, 1'b1, 1'b0);
        chk("b2b_valid1", 32'(out_valid), 32'd1);
        chk("b2b_imm1",   imm, 32'hFFFFFFFF);

        cyc(1'b1, 32'h40335293, 1'b1, 1'b1);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_alu",   32'(alu_control), 32'd0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);

        for (int k = 0; k < 3; k++) cyc(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
        chk("ill_flag",  32'(illegal), 32'd1);
        chk("ill_alu",   32'(alu_control), 32'hA);
        chk("ill_count", 32'(illegal_count), 32'd3);
        cyc(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
        chk("ill_count4", 32'(illegal_count), 32'd4);
        chk("sat_count",  32'(s_illegal_count), 32'd3);
        cyc(1'b1, 32'h202081B3, 1'b1, 1'b0);
        cyc(1'b1, 32'h40209093, 1'b1, 1'b0);
        cyc(1'b1, 32'h00202063, 1'b1, 1'b1);
        cyc(1'b1, 32'h00202063, 1'b1, 1'b0);
        chk("bad_br_count", 32'(illegal_count), 32'd7);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);

        // Reset while a stalled transfer is held
        cyc(1'b1, 32'h002081B3, 1'b1, 1'b0);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_alu",   32'(alu_control), 32'hA);
        chk("arst_count", 32'(illegal_count), 32'd0);
        chk("arst_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("arst_noacc", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        rst = 1'b0;
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
